// File: rtl/cdc_bundle_tx.sv
// cdc_bundle_tx: source side of a two-phase (toggle) bundled-data crossing.
// A word accepted from the valid/ready producer is parked on out_dat and
// announced by toggling out_req. The next word is not accepted until the
// destination's acknowledge toggle, synchronized into clk, matches out_req.
module cdc_bundle_tx #(
  parameter int W           = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_vld,
  input  logic [W-1:0] in_dat,
  output logic         in_rdy,
  output logic         out_req,
  output logic [W-1:0] out_dat,
  input  logic         out_ack,
  output logic         busy,
  output logic         err
);

  // ALIGN -> IDLE flips a single state bit, so the one transition that
  // looks at the raw ack input can only resolve to "stay" or "go".
  localparam logic [1:0] ALIGN = 2'b00;
  localparam logic [1:0] IDLE  = 2'b01;
  localparam logic [1:0] BUSY  = 2'b10;

  logic [1:0]             state_reg;
  logic [1:0]             state_next;
  logic                   out_req_reg;
  logic [W-1:0]           out_dat_reg;
  logic                   err_reg;
  logic [SYNC_STAGES-1:0] sync_reg;
  logic [SYNC_STAGES-1:0] sync_next;
  logic                   ack_s;
  logic                   chain_settled;
  logic                   launch;
  logic                   err_set;

  // Next value of every synchronizer stage: stage 0 samples the pin,
  // each later stage samples the one before it.
  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync_next
      if (gi == 0) begin : g_first
        assign sync_next[gi] = out_ack;
      end else begin : g_rest
        assign sync_next[gi] = sync_reg[gi-1];
      end
    end
  endgenerate

  // Acknowledge synchronizer chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_reg <= '0;
    else     sync_reg <= sync_next;
  end

  assign ack_s = sync_reg[SYNC_STAGES-1];

  // Leaving ALIGN needs the whole chain, and the pin feeding it, to agree
  // with out_req. Right after reset the chain holds zeros regardless of the
  // pin, so checking only ack_s would let a still-high ack from an abandoned
  // transfer slip into IDLE and then be flagged as a spurious toggle.
  assign chain_settled = (sync_reg == {SYNC_STAGES{out_req_reg}}) &&
                         (out_ack == out_req_reg);

  // Handshake state machine; a mismatch in IDLE is a spurious ack and
  // suppresses any launch in that cycle.
  always_comb begin
    state_next = state_reg;
    launch     = 1'b0;
    err_set    = 1'b0;
    case (state_reg)
      ALIGN: begin
        if (chain_settled) state_next = IDLE;
      end
      IDLE: begin
        if (ack_s != out_req_reg) begin
          err_set    = 1'b1;
          state_next = ALIGN;
        end else if (in_vld) begin
          launch     = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (ack_s == out_req_reg) state_next = IDLE;
      end
      default: state_next = ALIGN;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= ALIGN;
    else     state_reg <= state_next;
  end

  // Request toggle and bundled data move only on a launch edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_req_reg <= 1'b0;
      out_dat_reg <= '0;
    end else if (launch) begin
      out_req_reg <= ~out_req_reg;
      out_dat_reg <= in_dat;
    end
  end

  // Sticky protocol error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          err_reg <= 1'b0;
    else if (err_set) err_reg <= 1'b1;
  end

  assign in_rdy  = (state_reg == IDLE);
  assign busy    = (state_reg == BUSY);
  assign out_req = out_req_reg;
  assign out_dat = out_dat_reg;
  assign err     = err_reg;

endmodule

// File: tb/tb_cdc_bundle_tx.sv
// Testbench for cdc_bundle_tx: scoreboard of launched words checked on every
// out_req toggle, plus per-scenario cycle-accurate checks.
module tb_cdc_bundle_tx;
  localparam int W  = 32;
  localparam int SS = 2;

  logic         clk = 1'b0;
  logic         clk_en = 1'b0;
  logic         rst = 1'b0;
  logic         in_vld = 1'b0;
  logic [W-1:0] in_dat = '0;
  logic         in_rdy;
  logic         out_req;
  logic [W-1:0] out_dat;
  logic         out_ack = 1'b0;
  logic         busy;
  logic         err;

  int n_checks = 0;
  int n_errors = 0;
  int n_toggles = 0;
  bit mon_en = 1'b0;
  bit dest_auto = 1'b0;
  logic [W-1:0] exp_q[$];
  logic         prev_req = 1'b0;
  logic [W-1:0] prev_dat = '0;

  cdc_bundle_tx #(.W(W), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_dat(in_dat), .in_rdy(in_rdy),
    .out_req(out_req), .out_dat(out_dat), .out_ack(out_ack), .busy(busy), .err(err)
  );

  initial forever #5 clk = clk_en ? ~clk : clk;

  // Destination model: acks 3 negedges after seeing a new request toggle.
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (dest_auto && (out_req !== out_ack)) begin
        cnt++;
        if (cnt == 3) begin
          out_ack = out_req;
          cnt = 0;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Scoreboard monitor: every request toggle must carry the next queued word;
  // between toggles the bundled data must not move.
  always @(posedge clk) begin
    #1;
    if (mon_en && !rst) begin
      if (out_req !== prev_req) begin
        n_toggles++;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL sb_unexpected_launch: got out_dat=%h, required no launch", out_dat);
        end else begin
          logic [W-1:0] e;
          e = exp_q.pop_front();
          $display("launch req=%0d dat=%h exp=%h", out_req, out_dat, e);
          if (out_dat !== e) begin
            n_errors++;
            $display("FAIL sb_word: got out_dat=%h, required %h", out_dat, e);
          end
        end
      end else if (out_dat !== prev_dat) begin
        n_checks++;
        n_errors++;
        $display("FAIL sb_stable: out_dat moved %h -> %h without a req toggle", prev_dat, out_dat);
      end
    end
    prev_req = out_req;
    prev_dat = out_dat;
  end

  task automatic do_reset();
    mon_en = 1'b0;
    dest_auto = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    in_vld = 1'b0;
    in_dat = '0;
    out_ack = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    n_toggles = 0;
  endtask

  // Queue a word, present it, and return just after the edge that takes it.
  task automatic present_and_launch(input logic [W-1:0] w);
    exp_q.push_back(w);
    @(negedge clk);
    in_vld = 1'b1;
    in_dat = w;
    for (int i = 0; i < 40 && !in_rdy; i++) @(negedge clk);
    n_checks++;
    if (!in_rdy) begin
      n_errors++;
      $display("FAIL launch_timeout: in_rdy=%b, required 1 within 40 cycles", in_rdy);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3 rst = 1'b1;
    #1;
    n_checks++;
    if ({in_rdy, busy, err, out_req} !== 4'b0000 || out_dat !== '0) begin
      n_errors++;
      $display("FAIL reset_async: rdy/busy/err/req=%b dat=%h, required 0000 dat=0",
               {in_rdy, busy, err, out_req}, out_dat);
    end
    clk_en = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if (in_rdy !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_pre_edge: in_rdy=%b, required 0", in_rdy);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if ({in_rdy, busy, err} !== 3'b100) begin
      n_errors++;
      $display("FAIL reset_first_edge: rdy/busy/err=%b, required 100", {in_rdy, busy, err});
    end
    $display("reset: rdy=%b busy=%b err=%b", in_rdy, busy, err);
  endtask

  task automatic test_single();
    do_reset();
    mon_en = 1'b1;
    present_and_launch(32'hDEADBEEF);
    n_checks++;
    if ({out_req, in_rdy, busy} !== 3'b101 || out_dat !== 32'hDEADBEEF) begin
      n_errors++;
      $display("FAIL single_launch: req/rdy/busy=%b dat=%h, required 101 dat=deadbeef",
               {out_req, in_rdy, busy}, out_dat);
    end
    @(negedge clk);
    in_vld = 1'b0;
    in_dat = '0;
    @(negedge clk);
    out_ack = 1'b1;
    // Ack first sampled at the next edge k; IDLE after edge k+SS.
    for (int i = 0; i <= SS; i++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (in_rdy !== (i == SS) || out_dat !== 32'hDEADBEEF) begin
        n_errors++;
        $display("FAIL single_ack_edge%0d: in_rdy=%b dat=%h, required %b dat=deadbeef",
                 i, in_rdy, out_dat, (i == SS));
      end
    end
    n_checks++;
    if (exp_q.size() != 0 || err !== 1'b0) begin
      n_errors++;
      $display("FAIL single_done: pending=%0d err=%b, required 0 0", exp_q.size(), err);
    end
    $display("single: req=%b dat=%h rdy=%b", out_req, out_dat, in_rdy);
  endtask

  task automatic test_back_to_back();
    do_reset();
    mon_en = 1'b1;
    dest_auto = 1'b1;
    present_and_launch(32'h1);
    present_and_launch(32'h2);
    present_and_launch(32'h3);
    @(negedge clk);
    in_vld = 1'b0;
    for (int i = 0; i < 40 && !in_rdy; i++) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0 || n_toggles != 3 || out_req !== 1'b1 ||
        out_dat !== 32'h3 || in_rdy !== 1'b1) begin
      n_errors++;
      $display("FAIL b2b_end: pending=%0d toggles=%0d req=%b dat=%h rdy=%b, required 0 3 1 3 1",
               exp_q.size(), n_toggles, out_req, out_dat, in_rdy);
    end
    $display("back_to_back: toggles=%0d req=%b dat=%h", n_toggles, out_req, out_dat);
  endtask

  task automatic test_stall();
    bit done;
    do_reset();
    mon_en = 1'b1;
    present_and_launch(32'h000000A5);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_dat = $urandom;
      @(posedge clk);
      #1;
      n_checks++;
      if (out_req !== 1'b1 || out_dat !== 32'hA5 || busy !== 1'b1) begin
        n_errors++;
        $display("FAIL stall_busy%0d: req=%b dat=%h busy=%b, required 1 a5 1",
                 i, out_req, out_dat, busy);
      end
    end
    @(negedge clk);
    out_ack = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (in_rdy) begin
        in_dat = 32'h5A5A5A5A;
        exp_q.push_back(32'h5A5A5A5A);
        done = 1'b1;
      end else begin
        in_dat = $urandom;
        @(negedge clk);
      end
    end
    n_checks++;
    if (!done) begin
      n_errors++;
      $display("FAIL stall_timeout: in_rdy=%b, required 1", in_rdy);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (out_req !== 1'b0 || out_dat !== 32'h5A5A5A5A || exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL stall_relaunch: req=%b dat=%h pending=%0d, required 0 5a5a5a5a 0",
               out_req, out_dat, exp_q.size());
    end
    @(negedge clk);
    in_vld = 1'b0;
    $display("stall: req=%b dat=%h", out_req, out_dat);
  endtask

  task automatic test_spurious_ack();
    do_reset();
    @(posedge clk);
    @(negedge clk);
    out_ack = 1'b1;
    for (int i = 0; i <= SS; i++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (err !== (i == SS) || in_rdy !== (i != SS)) begin
        n_errors++;
        $display("FAIL spurious_edge%0d: err=%b rdy=%b, required %b %b",
                 i, err, in_rdy, (i == SS), (i != SS));
      end
    end
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (in_rdy !== 1'b0 || err !== 1'b1 || out_req !== 1'b0) begin
      n_errors++;
      $display("FAIL spurious_hold: rdy=%b err=%b req=%b, required 0 1 0", in_rdy, err, out_req);
    end
    @(negedge clk);
    out_ack = 1'b0;
    for (int i = 0; i <= SS; i++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (in_rdy !== (i == SS) || err !== 1'b1) begin
        n_errors++;
        $display("FAIL spurious_recover%0d: rdy=%b err=%b, required %b 1",
                 i, in_rdy, err, (i == SS));
      end
    end
    $display("spurious_ack: rdy=%b err=%b", in_rdy, err);
  endtask

  task automatic test_reset_mid();
    do_reset();
    present_and_launch(32'hCAFEF00D);
    @(negedge clk);
    in_vld = 1'b0;
    out_ack = 1'b1;
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({out_req, in_rdy, busy, err} !== 4'b0000 || out_dat !== '0) begin
      n_errors++;
      $display("FAIL midrst_async: req/rdy/busy/err=%b dat=%h, required 0000 0",
               {out_req, in_rdy, busy, err}, out_dat);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (in_rdy !== 1'b0 || err !== 1'b0) begin
        n_errors++;
        $display("FAIL midrst_hold%0d: rdy=%b err=%b, required 0 0", i, in_rdy, err);
      end
    end
    @(negedge clk);
    out_ack = 1'b0;
    for (int i = 0; i <= SS; i++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (in_rdy !== (i == SS) || err !== 1'b0) begin
        n_errors++;
        $display("FAIL midrst_release%0d: rdy=%b err=%b, required %b 0",
                 i, in_rdy, err, (i == SS));
      end
    end
    $display("reset_mid: rdy=%b err=%b req=%b", in_rdy, err, out_req);
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_spurious_ack();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running, required completion");
    $fatal(1, "timeout");
  end

endmodule
